// File: rtl/tft_timing_gen.sv
// TFT raster timing generator: HSYNC/VSYNC/DE, pixel request and aligned RGB for the panel.
// Build option: define TFT_TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module tft_timing_gen #(
    parameter int H_SYNC      = 20,
    parameter int H_BP        = 26,
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 210,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 20,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 22,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_SETTLE = 1024,
    parameter int DATA_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    output logic              pix_req,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              frame_start,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              lcd_disp
);

    // state  | meaning
    // IDLE   | PLL unlocked, panel blanked
    // SETTLE | counting consecutive locked cycles
    // RUN    | raster counters running, panel on

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_OFF   = H_SYNC + H_BP;
    localparam int V_OFF   = V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_W = HW'(H_SYNC);
    localparam logic [VW-1:0] V_SYNC_W = VW'(V_SYNC);
    localparam logic [HW-1:0] H_OFF_W  = HW'(H_OFF);
    localparam logic [VW-1:0] V_OFF_W  = VW'(V_OFF);
    localparam logic [HW-1:0] H_END_W  = HW'(H_OFF + H_ACTIVE);
    localparam logic [VW-1:0] V_END_W  = VW'(V_OFF + V_ACTIVE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            run_en;
    logic            h_act, v_act, hs_act, vs_act, origin;
    logic            hs_s1, vs_s1, hs_s2, vs_s2;
    logic [DATA_W-1:0] rgb_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (locked) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!locked)
                    state_nxt = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!locked) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Any lock drop clears the count, so only an unbroken locked run reaches RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE && locked && settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Everything downstream clears on the same edge that leaves RUN.
    assign run_en   = (state == ST_RUN) && locked;
    assign lcd_disp = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst || !run_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign h_act  = (h_cnt >= H_OFF_W) && (h_cnt < H_END_W);
    assign v_act  = (v_cnt >= V_OFF_W) && (v_cnt < V_END_W);
    assign hs_act = (h_cnt < H_SYNC_W);
    assign vs_act = (v_cnt < V_SYNC_W);
    assign origin = (h_cnt == H_OFF_W) && (v_cnt == V_OFF_W);

    always_ff @(posedge clk) begin
        if (rst || !run_en) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
        end else begin
            pix_req     <= h_act && v_act;
            pix_x       <= (h_act && v_act) ? 10'(h_cnt - H_OFF_W) : 10'd0;
            pix_y       <= (h_act && v_act) ? 9'(v_cnt - V_OFF_W) : 9'd0;
            frame_start <= origin;
            hs_s1       <= hs_act;
            vs_s1       <= vs_act;
        end
    end

`ifdef TFT_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int CH_W  = DATA_W / 3;

    logic [9:0] bar_q;
    logic [2:0] bar_idx;

    // Bar colour bits: R = ~idx[1], G = ~idx[2], B = ~idx[0] gives white..black.
    always_comb begin
        bar_q   = pix_x / 10'(BAR_W);
        bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
        rgb_src = DATA_W'({{CH_W{~bar_idx[1]}}, {CH_W{~bar_idx[2]}}, {CH_W{~bar_idx[0]}}});
    end
`else
    assign rgb_src = rgb_in;
`endif

    always_ff @(posedge clk) begin
        if (rst || !run_en) begin
            lcd_de  <= 1'b0;
            lcd_rgb <= '0;
            hs_s2   <= 1'b0;
            vs_s2   <= 1'b0;
        end else begin
            lcd_de  <= pix_req;
            lcd_rgb <= pix_req ? rgb_src : '0;
            hs_s2   <= hs_s1;
            vs_s2   <= vs_s1;
        end
    end

    assign lcd_hs = hs_s2 ? SYNC_POL : ~SYNC_POL;
    assign lcd_vs = vs_s2 ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen using a 16x7 raster (8x4 active) and LOCK_SETTLE=4.
module tb_tft_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        locked = 1'b0;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_start;
    logic [23:0] rgb_in;
    logic        lcd_hs, lcd_vs, lcd_de, lcd_disp;
    logic [23:0] lcd_rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tft_timing_gen #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .SYNC_POL(1'b0), .LOCK_SETTLE(4), .DATA_W(24)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .rgb_in(rgb_in),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
        .lcd_disp(lcd_disp)
    );

    // Frame source answers the request in the same cycle pix_req is high.
    assign rgb_in = pix_req ? {5'd0, pix_x, pix_y} : 24'h5A5A5A;

    function automatic logic [23:0] exp_rgb(input logic [9:0] x, input logic [8:0] y);
`ifdef TFT_TEST_PATTERN_EN
        logic [2:0] xi;
        logic [23:0] c;
        xi = x[2:0];
        case (xi)
            3'd0: c = 24'hFFFFFF;
            3'd1: c = 24'hFFFF00;
            3'd2: c = 24'h00FFFF;
            3'd3: c = 24'h00FF00;
            3'd4: c = 24'hFF00FF;
            3'd5: c = 24'hFF0000;
            3'd6: c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        if (y > 9'd511) c = 24'h0;
        return c;
`else
        return {5'd0, x, y};
`endif
    endfunction

    task automatic wait_disp(output int n);
        n = 0;
        while (lcd_disp !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_first_req(output int n);
        n = 0;
        while (pix_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_req, frame_start, lcd_de, lcd_disp, lcd_hs, lcd_vs} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000011",
                     {pix_req, frame_start, lcd_de, lcd_disp, lcd_hs, lcd_vs});
        end
        checks++;
        if ({pix_x, pix_y} !== 19'd0) begin
            errors++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", pix_x, pix_y);
        end
        checks++;
        if (lcd_rgb !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000000", lcd_rgb);
        end
    endtask

    task automatic test_startup;
        int n;
        rst = 1'b0;
        locked = 1'b1;
        wait_disp(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL startup_disp_latency: got %0d edges expected 5", n);
        end
        wait_first_req(n);
        checks++;
        if (n != 39) begin
            errors++;
            $display("FAIL startup_first_req: got %0d cycles expected 39", n);
        end
        checks++;
        if ({frame_start, pix_x, pix_y, lcd_de} !== {1'b1, 10'd0, 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL startup_origin: got fs=%b x=%0d y=%0d de=%b expected fs=1 x=0 y=0 de=0",
                     frame_start, pix_x, pix_y, lcd_de);
        end
    endtask

    // Observes one 112-cycle frame starting at the first pix_req.
    task automatic test_frame;
        int cnt_req = 0, cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_fs = 0;
        int lag_err = 0, rgb_err = 0, seq_err = 0;
        logic prev_req = 1'b0;
        logic [9:0] prev_x = '0, ex_x = '0;
        logic [8:0] prev_y = '0, ex_y = '0;
        logic [23:0] want;
        for (int i = 0; i < 112; i++) begin
            if (pix_req === 1'b1) begin
                cnt_req++;
                if (pix_x !== ex_x || pix_y !== ex_y) seq_err++;
                if (ex_x == 10'd7) begin
                    ex_x = '0;
                    ex_y = ex_y + 1'b1;
                end else begin
                    ex_x = ex_x + 1'b1;
                end
            end
            if (lcd_de === 1'b1) cnt_de++;
            if (lcd_de !== prev_req) lag_err++;
            want = prev_req ? exp_rgb(prev_x, prev_y) : 24'h0;
            if (lcd_rgb !== want) rgb_err++;
            if (lcd_hs === 1'b0) cnt_hs++;
            if (lcd_vs === 1'b0) cnt_vs++;
            if (frame_start === 1'b1) cnt_fs++;
            prev_req = pix_req;
            prev_x = pix_x;
            prev_y = pix_y;
            @(negedge clk);
        end
        checks++;
        if (cnt_req != 32) begin errors++; $display("FAIL frame_req_count: got %0d expected 32", cnt_req); end
        checks++;
        if (cnt_de != 32) begin errors++; $display("FAIL frame_de_count: got %0d expected 32", cnt_de); end
        checks++;
        if (cnt_hs != 28) begin errors++; $display("FAIL frame_hs_low: got %0d expected 28", cnt_hs); end
        checks++;
        if (cnt_vs != 16) begin errors++; $display("FAIL frame_vs_low: got %0d expected 16", cnt_vs); end
        checks++;
        if (cnt_fs != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", cnt_fs); end
        checks++;
        if (seq_err != 0) begin errors++; $display("FAIL frame_xy_order: got %0d bad coords expected 0", seq_err); end
        checks++;
        if (lag_err != 0) begin errors++; $display("FAIL frame_de_lag: got %0d bad cycles expected 0", lag_err); end
        checks++;
        if (rgb_err != 0) begin errors++; $display("FAIL frame_rgb: got %0d bad cycles expected 0", rgb_err); end
    endtask

    task automatic test_lock_drop;
        int n = 0;
        while (!(pix_req === 1'b1 && pix_x == 10'd2 && pix_y == 9'd1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drop_find_position: got timeout expected pix_x=2 pix_y=1");
        end
        checks++;
        if (lcd_de !== 1'b1) begin
            errors++;
            $display("FAIL drop_de_before: got %b expected 1", lcd_de);
        end
        locked = 1'b0;
        @(negedge clk);
        checks++;
        if ({lcd_de, lcd_disp, pix_req, lcd_hs, lcd_vs} !== 5'b00011 || lcd_rgb !== 24'h0) begin
            errors++;
            $display("FAIL drop_blank: got de=%b disp=%b req=%b hs=%b vs=%b rgb=%h expected 0 0 0 1 1 000000",
                     lcd_de, lcd_disp, pix_req, lcd_hs, lcd_vs, lcd_rgb);
        end
        locked = 1'b1;
        wait_disp(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL drop_relock_latency: got %0d edges expected 5", n);
        end
        checks++;
        if (lcd_hs !== 1'b1) begin
            errors++;
            $display("FAIL drop_hs_run0: got %b expected 1", lcd_hs);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({lcd_hs, lcd_vs} !== 2'b00) begin
            errors++;
            $display("FAIL drop_restart_sync: got hs=%b vs=%b expected 0 0", lcd_hs, lcd_vs);
        end
        wait_first_req(n);
        checks++;
        if (n != 37 || frame_start !== 1'b1 || pix_x !== 10'd0 || pix_y !== 9'd0) begin
            errors++;
            $display("FAIL drop_restart_origin: got n=%0d fs=%b x=%0d y=%0d expected 37 1 0 0",
                     n, frame_start, pix_x, pix_y);
        end
    endtask

    task automatic test_settle_glitch;
        logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        locked = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            locked = pat[i];
            @(negedge clk);
            checks++;
            if (lcd_disp !== exp[i]) begin
                errors++;
                $display("FAIL settle_glitch_step%0d: got disp=%b expected %b", i, lcd_disp, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        while (lcd_de !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL rstmid_find_active: got timeout expected lcd_de=1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pix_req, frame_start, lcd_de, lcd_disp, lcd_hs, lcd_vs} !== 6'b000011 ||
            {pix_x, pix_y} !== 19'd0 || lcd_rgb !== 24'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b x=%0d y=%0d rgb=%h expected 000011 0 0 000000",
                     {pix_req, frame_start, lcd_de, lcd_disp, lcd_hs, lcd_vs}, pix_x, pix_y, lcd_rgb);
        end
        rst = 1'b0;
        wait_disp(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rstmid_restart_latency: got %0d edges expected 5", n);
        end
    endtask

    initial begin
        test_reset;
        test_startup;
        test_frame;
        test_lock_drop;
        test_settle_glitch;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
